// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types for the two-port memory arbiter.
//   state_t        : arbiter FSM state (IDLE, ISSUE, WAIT)
//   PORT_F/PORT_D  : requester ids (instruction fetch / load-store)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick -- combinational winner selection for mem_arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   : a tie grants the port that did not win most recently
//               (lastGrant input present).
//   undefined : a tie always grants the load/store port (no lastGrant input).
// Ports:
//   F_req, D_req : requests from fetch and load/store ports
//   lastGrant    : id of the most recent winner (round-robin build only)
//   winner       : id of the selected port (only meaningful when a req is high)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic F_req,
  input  logic D_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic lastGrant,
`endif
  output logic winner
);

  always_comb begin
    winner = PORT_F;
    if (F_req && D_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = (lastGrant == PORT_F) ? PORT_D : PORT_F;
`else
      winner = PORT_D;
`endif
    end else if (D_req) begin
      winner = PORT_D;
    end else begin
      winner = PORT_F;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates a read-only fetch port (F) and a load/store
// port (D) onto one shared memory with a fixed read latency.
// Build option: MEM_ARB_ROUND_ROBIN_EN (tie policy, see mem_arb_pick).
// Parameters: DATA_W, ADDR_W, MEM_LAT (read latency, legal 1..3).
// Ports:
//   clock, reset_n                     : clock, async active-low reset
//   F_req/F_addr/F_gnt/F_rvalid/F_rdata: fetch requester
//   D_req/D_we/D_addr/D_wdata/D_gnt/D_rvalid/D_rdata : load/store requester
//   MemRead/MemWrite/MemIn/WriteData/MemOut : shared memory
//   busy     : high whenever the FSM is not IDLE
//   dbgState : current FSM state, for observation only
//
// Handshake: a requester raises req with addr/we/wdata and holds them stable
// until it sees gnt. The request is accepted on the rising edge where the FSM
// is IDLE and the port wins; gnt is a one-cycle pulse in the following ISSUE
// cycle. Dropping req before acceptance cancels the access. For reads, rvalid
// pulses for one cycle MEM_LAT+1 cycles after the ISSUE cycle and rdata holds
// until the next read completion for that port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              F_req,
  input  logic [ADDR_W-1:0] F_addr,
  output logic              F_gnt,
  output logic              F_rvalid,
  output logic [DATA_W-1:0] F_rdata,
  input  logic              D_req,
  input  logic              D_we,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic              D_gnt,
  output logic              D_rvalid,
  output logic [DATA_W-1:0] D_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemIn,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] MemOut,
  output logic              busy,
  output state_t            dbgState
);

  // MEM_LAT is limited to 1..3, so a 2-bit latency counter suffices.
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

  state_t            state;
  state_t            stateNext;
  logic [1:0]        cnt;
  logic [1:0]        cntNext;
  logic              accept;
  logic              capture;
  logic              winner;
  logic              winReg;
  logic              weReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lastGrant;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lastGrant <= PORT_F;
    end else if (accept) begin
      lastGrant <= winner;
    end
  end

  mem_arb_pick uPick (
    .F_req     (F_req),
    .D_req     (D_req),
    .lastGrant (lastGrant),
    .winner    (winner)
  );
`else
  mem_arb_pick uPick (
    .F_req  (F_req),
    .D_req  (D_req),
    .winner (winner)
  );
`endif

  // FSM state and latency counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (F_req || D_req) begin
          accept    = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (weReg) begin
          stateNext = IDLE;
        end else begin
          stateNext = WAIT;
          cntNext   = LAT_INIT;
        end
      end
      WAIT: begin
        cntNext = cnt - 2'd1;
        // Memory data is valid during the last WAIT cycle.
        if (cnt == 2'd1) begin
          capture   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Latched request, read-return registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      winReg   <= PORT_F;
      weReg    <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      F_rvalid <= 1'b0;
      D_rvalid <= 1'b0;
      F_rdata  <= '0;
      D_rdata  <= '0;
    end else begin
      if (accept) begin
        winReg   <= winner;
        weReg    <= (winner == PORT_D) ? D_we : 1'b0;
        addrReg  <= (winner == PORT_D) ? D_addr : F_addr;
        wdataReg <= (winner == PORT_D) ? D_wdata : '0;
      end
      F_rvalid <= capture && (winReg == PORT_F);
      D_rvalid <= capture && (winReg == PORT_D);
      if (capture && (winReg == PORT_F)) begin
        F_rdata <= MemOut;
      end
      if (capture && (winReg == PORT_D)) begin
        D_rdata <= MemOut;
      end
    end
  end

  assign F_gnt     = (state == ISSUE) && (winReg == PORT_F);
  assign D_gnt     = (state == ISSUE) && (winReg == PORT_D);
  assign MemRead   = (state == ISSUE) && !weReg;
  assign MemWrite  = (state == ISSUE) && weReg;
  assign MemIn     = addrReg;
  assign WriteData = wdataReg;
  assign busy      = (state != IDLE);
  assign dbgState  = state;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the memory data width.
REQ-002 Parameter ADDR_W, default 16, SHALL set the memory address width.
REQ-003 Parameter MEM_LAT, default 1, legal 1..3, SHALL set the Memory read latency in cycles.
REQ-004 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Ports F_req in 1, F_addr in ADDR_W, F_gnt out 1, F_rvalid out 1, F_rdata out DATA_W SHALL form the read-only instruction-fetch requester port.
REQ-007 Ports D_req in 1, D_we in 1, D_addr in ADDR_W, D_wdata in DATA_W, D_gnt out 1, D_rvalid out 1, D_rdata out DATA_W SHALL form the load/store requester port.
REQ-008 Ports MemRead out 1, MemWrite out 1, MemIn out ADDR_W (address), WriteData out DATA_W, MemOut in DATA_W SHALL connect to the shared Memory.
REQ-009 Port busy, output, 1, SHALL be high whenever state is not IDLE.

Function
REQ-010 FSM SHALL have states IDLE, ISSUE, WAIT only.
REQ-011 IDLE: on a rising edge with any req high, SHALL select a winner, latch its addr/we/wdata, go to ISSUE; with no req, stay IDLE.
REQ-012 Requesters hold req/addr/we/wdata stable until their gnt; req dropped before acceptance SHALL cause no access.
REQ-013 ISSUE: winner's gnt SHALL be high for exactly this one cycle; MemIn/WriteData driven from latched values.
REQ-014 ISSUE write (D_we latched 1): MemWrite high this cycle only, next state IDLE, no rvalid.
REQ-015 ISSUE read: MemRead high this cycle only, next state WAIT with latency counter loaded to MEM_LAT.
REQ-016 WAIT: counter decrements each cycle; on the edge ending the cycle where counter equals 1, SHALL capture MemOut into winner's rdata and go IDLE.
REQ-017 Winner's rvalid SHALL be high for exactly the one cycle after capture; rdata SHALL hold its value until the next capture for that port.
REQ-018 Read latency, accept edge to rvalid high: MEM_LAT+2 cycles; write occupies 2 cycles (IDLE+ISSUE).
REQ-019 MemRead and MemWrite SHALL never be high simultaneously; both low outside ISSUE.
REQ-020 A new request SHALL be acceptable on the same edge that ends rvalid's first IDLE cycle (back-to-back reads allowed).
REQ-021 Only one outstanding access at a time; requests arriving in ISSUE/WAIT wait until IDLE.
REQ-022 Single requester: SHALL be granted regardless of arbitration history.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, counter 0, last-grant = F, and all outputs (gnts, rvalids, rdatas, MemRead, MemWrite, MemIn, WriteData, busy) to 0.
REQ-024 Reset during ISSUE or WAIT SHALL abort the access; no rvalid SHALL be produced for it after release.

Configuration
REQ-025 Macro MEM_ARB_ROUND_ROBIN_EN defined: tie (both req in IDLE) SHALL grant the port not granted most recently; last-grant resets to F, so first tie goes to D.
REQ-026 Macro undefined: ties SHALL always grant D (fixed priority); last-grant register SHALL not exist.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the FSM state typedef and port-id constants (PORT_F, PORT_D).
REQ-028 Winner selection SHALL live in sub-module mem_arb_pick (combinational; inputs F_req, D_req, last-grant; output winner id), containing the macro-dependent logic.

Verification
REQ-029 F_req alone, F_addr=0x0010, MEM_LAT=1, Memory[0x0010]=0x1234 -> F_gnt 1 cycle, MemRead 1 cycle, F_rvalid 3 cycles after accept with F_rdata=0x1234.
REQ-030 D_req, D_we=1, D_addr=0x0001, D_wdata=0xAAAA -> MemWrite 1 cycle with MemIn=0x0001, WriteData=0xAAAA; no D_rvalid; later D read returns 0xAAAA.
REQ-031 F_req and D_req held high for 4 accesses with ROUND_ROBIN_EN -> grant order D,F,D,F; without macro -> D,D,D,D.
REQ-032 MEM_LAT=3 read -> MemRead once, WAIT 3 cycles, rvalid 5 cycles after accept; busy high through ISSUE+WAIT.
REQ-033 reset_n low in second WAIT cycle -> all outputs 0 at once; after release no rvalid, next request serviced normally.
REQ-034 Every test: assert MemRead&&MemWrite never 1 and each gnt/rvalid pulse exactly one cycle wide.
